// File: rtl/jt12_div_ctl.sv
// Purpose : prescaler controller; decodes bank-0 writes to 0x2D/0x2E/0x2F into div_setting_o,
//           applying each change only on a prescaler boundary (cen_i & clk_en_i) or after a timeout.
// Latency : busy_o rises 1 clk after the causing write; div_setting_o/upd_o update 1 clk after the apply cycle.
// Backpressure: none; writes are always accepted and merge into the pending target while busy.
//
// Ports:
//   clk_i          system clock, all logic on posedge
//   rst_i          synchronous reset, active-low
//   cen_i          clock enable shared with the divider
//   clk_en_i       divider FM enable, marks a prescaler boundary
//   wr_en_i        one-cycle register write strobe
//   wr_a1_i        bank select, only bank 0 is decoded
//   wr_addr_i      register address
//   div_setting_o  prescaler select to the divider
//   busy_o         update pending or settling
//   upd_o          one-cycle pulse when div_setting_o takes a new value
//
// Build option: define JT12_DIV_CTL_IMMEDIATE_EN to apply updates on the first cen_i after
// entering WAIT, ignoring clk_en_i and TIMEOUT.
module jt12_div_ctl #(
    parameter logic [1:0] RESET_DIV = 2'b10,
    parameter logic [3:0] SETTLE    = 4'd6,
    parameter logic [4:0] TIMEOUT   = 5'd24,
    parameter bit         LOCK_DIV  = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cen_i,
    input  logic       clk_en_i,
    input  logic       wr_en_i,
    input  logic       wr_a1_i,
    input  logic [7:0] wr_addr_i,
    output logic [1:0] div_setting_o,
    output logic       busy_o,
    output logic       upd_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] div_q, div_d;
    logic [1:0] target_q, target_d;
    logic [4:0] tmo_q, tmo_d;
    logic [3:0] set_q, set_d;
    logic       busy_q;
    logic       upd_q;
    logic       wr_hit;
    logic       apply_ok;
    logic       apply;

    assign wr_hit = wr_en_i & ~wr_a1_i & ~LOCK_DIV;

`ifdef JT12_DIV_CTL_IMMEDIATE_EN
    assign apply_ok = cen_i;
`else
    // A boundary normally carries the update; the timeout covers a stalled divider.
    assign apply_ok = cen_i & (clk_en_i | (tmo_q == TIMEOUT - 5'd1));
`endif

    // Register decode: 0x2D/0x2E set bits on top of the current target, 0x2F clears both.
    always_comb begin
        target_d = target_q;
        if (wr_hit) begin
            case (wr_addr_i)
                8'h2D:   target_d = target_q | 2'b10;
                8'h2E:   target_d = target_q | 2'b01;
                8'h2F:   target_d = 2'b00;
                default: target_d = target_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        tmo_d   = tmo_q;
        set_d   = set_q;
        apply   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (target_d != div_q) begin
                    state_d = ST_WAIT;
                    tmo_d   = 5'd0;
                end
            end
            ST_WAIT: begin
                // The registered target is used so a write landing on the apply
                // cycle is deferred to the end of SETTLE rather than applied early.
                if (target_q == div_q) begin
                    state_d = ST_IDLE;
                    tmo_d   = 5'd0;
                end else if (apply_ok) begin
                    div_d   = target_q;
                    apply   = 1'b1;
                    tmo_d   = 5'd0;
                    set_d   = 4'd0;
                    state_d = ST_SETTLE;
                end else if (cen_i) begin
                    tmo_d = tmo_q + 5'd1;
                end
            end
            ST_SETTLE: begin
                if (cen_i) begin
                    if (set_q == SETTLE - 4'd1) begin
                        set_d = 4'd0;
                        // Include a same-cycle write so it is not stranded in IDLE.
                        if (target_d != div_q) begin
                            state_d = ST_WAIT;
                            tmo_d   = 5'd0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        set_d = set_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmo_d   = 5'd0;
                set_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            div_q    <= RESET_DIV;
            target_q <= RESET_DIV;
            tmo_q    <= 5'd0;
            set_q    <= 4'd0;
            busy_q   <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            target_q <= target_d;
            tmo_q    <= tmo_d;
            set_q    <= set_d;
            busy_q   <= (state_d != ST_IDLE);
            upd_q    <= apply;
        end
    end

    assign div_setting_o = div_q;
    assign busy_o        = busy_q;
    assign upd_o         = upd_q;

endmodule

// File: tb/tb_jt12_div_ctl.sv
// Purpose : directed bench for jt12_div_ctl; expected updates queued by stimulus, checked by a monitor.
// Latency : upd expected on the clock after the apply cycle.
// Backpressure: n/a.
module tb_jt12_div_ctl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       cen_i = 1'b0;
    logic       clk_en_i = 1'b0;
    logic       wr_en_i = 1'b0;
    logic       wr_a1_i = 1'b0;
    logic [7:0] wr_addr_i = 8'h00;
    logic [1:0] div_o, lk_div_o;
    logic       busy_o, upd_o, lk_busy_o, lk_upd_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lk_upd_cnt = 0;

    typedef struct {
        logic [1:0] div;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    jt12_div_ctl dut (
        .clk_i(clk_i), .rst_i(rst_i), .cen_i(cen_i), .clk_en_i(clk_en_i),
        .wr_en_i(wr_en_i), .wr_a1_i(wr_a1_i), .wr_addr_i(wr_addr_i),
        .div_setting_o(div_o), .busy_o(busy_o), .upd_o(upd_o)
    );

    jt12_div_ctl #(.LOCK_DIV(1'b1)) dut_lk (
        .clk_i(clk_i), .rst_i(rst_i), .cen_i(cen_i), .clk_en_i(clk_en_i),
        .wr_en_i(wr_en_i), .wr_a1_i(wr_a1_i), .wr_addr_i(wr_addr_i),
        .div_setting_o(lk_div_o), .busy_o(lk_busy_o), .upd_o(lk_upd_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one clock worth of inputs; returns 1 time unit after the edge.
    task automatic step(input logic c, input logic ce, input logic we, input logic a1,
                        input logic [7:0] a);
        cen_i = c; clk_en_i = ce; wr_en_i = we; wr_a1_i = a1; wr_addr_i = a;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input logic c, input logic ce);
        step(c, ce, 1'b0, 1'b0, 8'h00);
    endtask

    // The next step's edge is expected to apply div.
    task automatic expect_upd(input logic [1:0] div);
        exp_t e;
        e.div = div;
        e.cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        repeat (3) idle(1'b1, 1'b1);
        rst_i = 1'b1;
    endtask

    // Monitor: every upd pulse must match the head of the expectation queue.
    always @(negedge clk_i) begin
        if (lk_upd_o) lk_upd_cnt++;
        if (upd_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_upd", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("upd_div", int'(div_o), int'(e.div));
                chk("upd_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        // 1: reset
        do_reset();
        chk("rst_div", int'(div_o), 2);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_upd", int'(upd_o), 0);
        idle(1'b0, 1'b0);
        chk("post_rst_div", int'(div_o), 2);
        chk("post_rst_busy", int'(busy_o), 0);

        // 2: 0x2E applied on the 4th cen with clk_en, cen gaps in between
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h2E);
        chk("t2_busy_rise", int'(busy_o), 1);
        chk("t2_div_hold", int'(div_o), 2);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b1);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        expect_upd(2'b11);
        idle(1'b1, 1'b1);
        chk("t2_div", int'(div_o), 3);
        repeat (2) idle(1'b1, 1'b0);
        repeat (2) idle(1'b0, 1'b1);
        chk("t2_busy_frozen", int'(busy_o), 1);
        repeat (3) idle(1'b1, 1'b0);
        chk("t2_busy_5cen", int'(busy_o), 1);
        idle(1'b1, 1'b0);
        chk("t2_busy_fall", int'(busy_o), 0);

        // reset while an update is pending discards it
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h2F);
        idle(1'b1, 1'b0);
        do_reset();
        repeat (3) idle(1'b1, 1'b1);
        chk("midrst_div", int'(div_o), 2);
        chk("midrst_busy", int'(busy_o), 0);

        // 3: 0x2F then 0x2D returns target to div_setting, no update
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h2F);
        chk("t3_busy", int'(busy_o), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h2D);
        idle(1'b1, 1'b1);
        chk("t3_busy_drop", int'(busy_o), 0);
        idle(1'b1, 1'b1);
        chk("t3_div", int'(div_o), 2);

        // writes that do not change anything while idle
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h2D);
        chk("same_wr_busy", int'(busy_o), 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h30);
        chk("other_addr_busy", int'(busy_o), 0);

        // 4: forced update after 24 cen with clk_en low
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h2F);
        for (int i = 0; i < 24; i++) begin
            if (i % 5 == 2) idle(1'b0, 1'b1);
            if (i == 23) expect_upd(2'b00);
            idle(1'b1, 1'b0);
        end
        chk("t4_div", int'(div_o), 0);

        // 5: 0x2E written during SETTLE is applied at the next boundary
        repeat (2) idle(1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h2E);
        repeat (4) idle(1'b1, 1'b0);
        chk("t5_busy_rewait", int'(busy_o), 1);
        chk("t5_div_hold", int'(div_o), 0);
        repeat (2) idle(1'b1, 1'b0);
        expect_upd(2'b01);
        idle(1'b1, 1'b1);
        chk("t5_div", int'(div_o), 1);
        repeat (6) idle(1'b1, 1'b0);
        chk("t5_busy_fall", int'(busy_o), 0);

        // 6: bank 1 ignored; locked instance ignores bank 0 too
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h2F);
        chk("t6_a1_busy", int'(busy_o), 0);
        chk("t6_a1_div", int'(div_o), 2);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h2F);
        chk("t6_busy", int'(busy_o), 1);
        chk("t6_lk_busy", int'(lk_busy_o), 0);
        expect_upd(2'b00);
        idle(1'b1, 1'b1);
        repeat (6) idle(1'b1, 1'b0);
        chk("t6_lk_div", int'(lk_div_o), 2);
        chk("t6_lk_busy_end", int'(lk_busy_o), 0);
        repeat (3) idle(1'b0, 1'b0);

        chk("pending_upd", exp_q.size(), 0);
        chk("lk_upd_count", lk_upd_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
